// File: rtl/pong_pkg.sv
// Purpose : shared types and defaults for the pong scoring path (score keeper + win detector).
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pong_pkg;

  // Rally sequencing states of the score keeper.
  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    OVER
  } score_state_t;

  // Points needed to win. The win detector must be built with the same value.
  localparam int SCORE_LIMIT_DEF = 15;

  // Serve hold time in clocks: 0.5 s at 50 MHz.
  localparam int SERVE_DELAY_DEF = 25_000_000;

  // One point added to a score, clamped at the limit.
  function automatic int sat_inc(input int score, input int limit);
    return (score >= limit) ? limit : score + 1;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Purpose : bundles the score keeper's point/win inputs and score/ball outputs.
// Latency : n/a (wires only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
//   master : score keeper side  (consumes points/wins, drives scores and ball control)
//   slave  : environment side   (ball logic, win detector, new-game button)
interface score_keeper_if;

  logic p1_point;     // 1-cycle pulse: paddle 1 scored
  logic p2_point;     // 1-cycle pulse: paddle 2 scored
  logic new_game;     // 1-cycle pulse: restart the match
  logic p1_win;       // win detector verdict on the current scores
  logic p2_win;
  int   p1_score;     // registered scores, 0..SCORE_LIMIT
  int   p2_score;
  logic ball_hold;    // 1 = ball frozen at centre
  logic ball_launch;  // 1-cycle pulse: release the ball
  logic serve_dir;    // 0 = toward paddle 1, 1 = toward paddle 2

  modport master (
    input  p1_point, p2_point, new_game, p1_win, p2_win,
    output p1_score, p2_score, ball_hold, ball_launch, serve_dir
  );

  modport slave (
    output p1_point, p2_point, new_game, p1_win, p2_win,
    input  p1_score, p2_score, ball_hold, ball_launch, serve_dir
  );

endinterface

// File: rtl/score_keeper.sv
// Purpose : counts points into two scores and sequences each rally (serve hold, launch, game over).
// Latency : point pulse -> score one clock later; serve launches SERVE_DELAY clocks after entering SERVE.
// Backpressure: none; point pulses outside PLAY are dropped by design.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   sk         : score_keeper_if.master (points, new_game, wins in; scores, ball control out)
module score_keeper
  import pong_pkg::*;
#(
  parameter int SCORE_LIMIT = SCORE_LIMIT_DEF,
  parameter int SERVE_DELAY = SERVE_DELAY_DEF  // must be >= 1
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.master sk
);

  localparam int            CW         = $clog2(SERVE_DELAY + 1);
  // Loading DELAY-1 and launching on the cycle cnt is seen at zero gives exactly
  // SERVE_DELAY cycles in SERVE, and a launch on the first SERVE cycle when DELAY=1.
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SERVE_DELAY - 1);

  score_state_t  r_state;
  logic [CW-1:0] r_cnt;
  int            r_p1_score;
  int            r_p2_score;
  logic          r_hold;
  logic          r_launch;
  logic          r_dir;

  logic w_win;
  logic w_p1_only;
  logic w_p2_only;
  logic w_any_point;

  assign w_win       = sk.p1_win | sk.p2_win;
  assign w_p1_only   = sk.p1_point & ~sk.p2_point;
  assign w_p2_only   = sk.p2_point & ~sk.p1_point;
  assign w_any_point = sk.p1_point | sk.p2_point;

  always_ff @(posedge clk) begin
    if (reset || sk.new_game) begin
      r_state    <= SERVE;
      r_cnt      <= CNT_RELOAD;
      r_p1_score <= 0;
      r_p2_score <= 0;
      r_hold     <= 1'b1;
      r_launch   <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      r_launch <= 1'b0;
      case (r_state)
        SERVE: begin
          r_hold <= 1'b1;
          // Win is checked first so the ball never launches after a winning point.
          if (w_win) begin
            r_state <= OVER;
          end else if (r_cnt == '0) begin
            r_state  <= PLAY;
            r_hold   <= 1'b0;
            r_launch <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        PLAY: begin
          r_hold <= 1'b0;
          // A simultaneous double point is treated as a dead ball: re-serve, no score.
          if (w_any_point) begin
            r_state <= SERVE;
            r_hold  <= 1'b1;
            r_cnt   <= CNT_RELOAD;
            if (w_p1_only) begin
              r_p1_score <= sat_inc(r_p1_score, SCORE_LIMIT);
              r_dir      <= 1'b1;  // serve toward the player who lost the point
            end else if (w_p2_only) begin
              r_p2_score <= sat_inc(r_p2_score, SCORE_LIMIT);
              r_dir      <= 1'b0;
            end
          end
        end
        OVER: begin
          r_hold <= 1'b1;
        end
        default: begin
          r_state <= SERVE;
          r_hold  <= 1'b1;
          r_cnt   <= CNT_RELOAD;
        end
      endcase
    end
  end

  assign sk.p1_score    = r_p1_score;
  assign sk.p2_score    = r_p2_score;
  assign sk.ball_hold   = r_hold;
  assign sk.ball_launch = r_launch;
  assign sk.serve_dir   = r_dir;

endmodule

// File: tb/tb_score_keeper.sv
// Purpose : self-checking bench for score_keeper with a stand-in win detector (score >= limit).
// Latency : reference model tracks serves by absolute launch edge rather than a down-counter.
// Backpressure: n/a; inputs change on the falling edge, outputs sampled on the falling edge.
module tb_score_keeper;

  localparam int SL = 3;
  localparam int SD = 4;

  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_OVER  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  score_keeper_if sk_if ();

  score_keeper #(
    .SCORE_LIMIT(SL),
    .SERVE_DELAY(SD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sk   (sk_if.master)
  );

  always #5 clk = ~clk;

  // Win detector beside the keeper, combinational on the live scores.
  assign sk_if.p1_win = (sk_if.p1_score >= SL);
  assign sk_if.p2_win = (sk_if.p2_score >= SL);

  // Reference model: a serve started at edge e launches at edge e+SD unless a win parks the game.
  int edge_no     = 0;
  int m_mode      = M_SERVE;
  int m_launch_at = SD;
  int m_p1        = 0;
  int m_p2        = 0;
  bit m_dir       = 1'b0;
  bit m_hold      = 1'b1;
  bit m_launch    = 1'b0;

  always @(posedge clk) begin
    edge_no  <= edge_no + 1;
    m_launch <= 1'b0;
    if (reset || sk_if.new_game) begin
      m_mode      <= M_SERVE;
      m_launch_at <= edge_no + 1 + SD;
      m_p1        <= 0;
      m_p2        <= 0;
      m_dir       <= 1'b0;
      m_hold      <= 1'b1;
    end else if (m_mode == M_SERVE) begin
      if (m_p1 >= SL || m_p2 >= SL) begin
        m_mode <= M_OVER;
        m_hold <= 1'b1;
      end else if (edge_no + 1 == m_launch_at) begin
        m_mode   <= M_PLAY;
        m_hold   <= 1'b0;
        m_launch <= 1'b1;
      end
    end else if (m_mode == M_PLAY) begin
      if (sk_if.p1_point || sk_if.p2_point) begin
        m_mode      <= M_SERVE;
        m_hold      <= 1'b1;
        m_launch_at <= edge_no + 1 + SD;
        if (sk_if.p1_point && !sk_if.p2_point) begin
          m_p1  <= (m_p1 + 1 > SL) ? SL : m_p1 + 1;
          m_dir <= 1'b1;
        end else if (sk_if.p2_point && !sk_if.p1_point) begin
          m_p2  <= (m_p2 + 1 > SL) ? SL : m_p2 + 1;
          m_dir <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one cycle of the given pulses, returning at the next falling edge.
  task automatic pulse(input logic a, input logic b, input logic ng);
    sk_if.p1_point = a;
    sk_if.p2_point = b;
    sk_if.new_game = ng;
    @(negedge clk);
    sk_if.p1_point = 1'b0;
    sk_if.p2_point = 1'b0;
    sk_if.new_game = 1'b0;
  endtask

  // Cycles until ball_launch is seen, or -1 if it never arrives within the budget.
  task automatic wait_launch(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (sk_if.ball_launch === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int hold_cnt;
    int n;
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (sk_if.ball_hold !== 1'b1 || sk_if.ball_launch !== 1'b0 || sk_if.p1_score !== 0 ||
        sk_if.p2_score !== 0 || sk_if.serve_dir !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got hold=%b launch=%b score=%0d/%0d dir=%b want 1 0 0/0 0",
               sk_if.ball_hold, sk_if.ball_launch, sk_if.p1_score, sk_if.p2_score, sk_if.serve_dir);
    end
    reset    = 1'b0;
    hold_cnt = 1;
    n        = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sk_if.ball_launch === 1'b1) begin
        n = i;
        break;
      end
      if (sk_if.ball_hold === 1'b1) hold_cnt++;
    end
    checks++;
    if (n !== SD) begin
      failures++;
      $display("FAIL first_launch got cycle %0d want %0d", n, SD);
    end
    checks++;
    if (hold_cnt !== SD) begin
      failures++;
      $display("FAIL first_hold_len got %0d want %0d", hold_cnt, SD);
    end
    tick();
    checks++;
    if (sk_if.ball_launch !== 1'b0 || sk_if.ball_hold !== 1'b0 ||
        sk_if.p1_score !== 0 || sk_if.p2_score !== 0) begin
      failures++;
      $display("FAIL launch_one_cycle got launch=%b hold=%b score=%0d/%0d want 0 0 0/0",
               sk_if.ball_launch, sk_if.ball_hold, sk_if.p1_score, sk_if.p2_score);
    end
  endtask

  task automatic test_p1_point();
    int n;
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (sk_if.p1_score !== 1 || sk_if.p2_score !== 0 || sk_if.serve_dir !== 1'b1 ||
        sk_if.ball_hold !== 1'b1 || sk_if.ball_launch !== 1'b0) begin
      failures++;
      $display("FAIL p1_point got score=%0d/%0d dir=%b hold=%b launch=%b want 1/0 1 1 0",
               sk_if.p1_score, sk_if.p2_score, sk_if.serve_dir, sk_if.ball_hold, sk_if.ball_launch);
    end
    wait_launch(n);
    checks++;
    if (n !== SD) begin
      failures++;
      $display("FAIL p1_relaunch got cycle %0d want %0d", n, SD);
    end
  endtask

  task automatic test_both_points();
    int n;
    int p1_before;
    int p2_before;
    logic dir_before;
    p1_before  = m_p1;
    p2_before  = m_p2;
    dir_before = m_dir;
    pulse(1'b1, 1'b1, 1'b0);
    checks++;
    if (sk_if.p1_score !== p1_before || sk_if.p2_score !== p2_before ||
        sk_if.serve_dir !== dir_before || sk_if.ball_hold !== 1'b1) begin
      failures++;
      $display("FAIL both_points got score=%0d/%0d dir=%b hold=%b want %0d/%0d %b 1",
               sk_if.p1_score, sk_if.p2_score, sk_if.serve_dir, sk_if.ball_hold,
               p1_before, p2_before, dir_before);
    end
    wait_launch(n);
    checks++;
    if (n !== SD) begin
      failures++;
      $display("FAIL both_relaunch got cycle %0d want %0d", n, SD);
    end
  endtask

  task automatic test_p2_win();
    int n;
    int launches;
    int p1_before;
    p1_before = m_p1;
    for (int k = 0; k < SL; k++) begin
      pulse(1'b0, 1'b1, 1'b0);
      if (k < SL - 1) begin
        wait_launch(n);
        checks++;
        if (n !== SD) begin
          failures++;
          $display("FAIL p2_rally%0d_relaunch got cycle %0d want %0d", k, n, SD);
        end
      end
    end
    checks++;
    if (sk_if.p2_score !== SL || sk_if.p2_win !== 1'b1 || sk_if.serve_dir !== 1'b0) begin
      failures++;
      $display("FAIL p2_win_score got p2=%0d win=%b dir=%b want %0d 1 0",
               sk_if.p2_score, sk_if.p2_win, sk_if.serve_dir, SL);
    end
    launches = 0;
    for (int i = 0; i < 3 * SD; i++) begin
      sk_if.p1_point = (i % 3 == 0);
      sk_if.p2_point = (i % 3 == 1);
      tick();
      if (sk_if.ball_launch === 1'b1) launches++;
    end
    sk_if.p1_point = 1'b0;
    sk_if.p2_point = 1'b0;
    tick();
    checks++;
    if (launches !== 0 || sk_if.ball_hold !== 1'b1) begin
      failures++;
      $display("FAIL over_no_launch got launches=%0d hold=%b want 0 1", launches, sk_if.ball_hold);
    end
    checks++;
    if (sk_if.p1_score !== p1_before || sk_if.p2_score !== SL) begin
      failures++;
      $display("FAIL over_frozen got score=%0d/%0d want %0d/%0d",
               sk_if.p1_score, sk_if.p2_score, p1_before, SL);
    end
  endtask

  task automatic test_new_game();
    int n;
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (sk_if.p1_score !== 0 || sk_if.p2_score !== 0 || sk_if.serve_dir !== 1'b0 ||
        sk_if.ball_hold !== 1'b1 || sk_if.ball_launch !== 1'b0) begin
      failures++;
      $display("FAIL new_game_clear got score=%0d/%0d dir=%b hold=%b launch=%b want 0/0 0 1 0",
               sk_if.p1_score, sk_if.p2_score, sk_if.serve_dir, sk_if.ball_hold, sk_if.ball_launch);
    end
    wait_launch(n);
    checks++;
    if (n !== SD) begin
      failures++;
      $display("FAIL new_game_launch got cycle %0d want %0d", n, SD);
    end
  endtask

  task automatic test_abort();
    int n;
    // new_game with one serve cycle left; a point during SERVE must be dropped.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (sk_if.p1_score !== 1 || sk_if.p2_score !== 0 || sk_if.ball_hold !== 1'b1) begin
      failures++;
      $display("FAIL serve_point_ignored got score=%0d/%0d hold=%b want 1/0 1",
               sk_if.p1_score, sk_if.p2_score, sk_if.ball_hold);
    end
    tick();
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (sk_if.ball_launch !== 1'b0 || sk_if.ball_hold !== 1'b1 || sk_if.p1_score !== 0) begin
      failures++;
      $display("FAIL new_game_abort got launch=%b hold=%b p1=%0d want 0 1 0",
               sk_if.ball_launch, sk_if.ball_hold, sk_if.p1_score);
    end
    wait_launch(n);
    checks++;
    if (n !== SD) begin
      failures++;
      $display("FAIL new_game_abort_restart got cycle %0d want %0d", n, SD);
    end
    // Same again, aborted by reset.
    pulse(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (sk_if.ball_launch !== 1'b0 || sk_if.ball_hold !== 1'b1 || sk_if.p2_score !== 0) begin
      failures++;
      $display("FAIL reset_abort got launch=%b hold=%b p2=%0d want 0 1 0",
               sk_if.ball_launch, sk_if.ball_hold, sk_if.p2_score);
    end
    wait_launch(n);
    checks++;
    if (n !== SD) begin
      failures++;
      $display("FAIL reset_abort_restart got cycle %0d want %0d", n, SD);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sk_if.p1_point = ($urandom_range(0, 5) == 0);
      sk_if.p2_point = ($urandom_range(0, 5) == 0);
      sk_if.new_game = ($urandom_range(0, 149) == 0);
      reset          = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (sk_if.p1_score !== m_p1 || sk_if.p2_score !== m_p2 || sk_if.ball_hold !== m_hold ||
          sk_if.ball_launch !== m_launch || sk_if.serve_dir !== m_dir) begin
        failures++;
        $display("FAIL random_cycle%0d got score=%0d/%0d hold=%b launch=%b dir=%b want %0d/%0d %b %b %b",
                 i, sk_if.p1_score, sk_if.p2_score, sk_if.ball_hold, sk_if.ball_launch,
                 sk_if.serve_dir, m_p1, m_p2, m_hold, m_launch, m_dir);
      end
    end
    sk_if.p1_point = 1'b0;
    sk_if.p2_point = 1'b0;
    sk_if.new_game = 1'b0;
    reset          = 1'b0;
  endtask

  initial begin
    sk_if.p1_point = 1'b0;
    sk_if.p2_point = 1'b0;
    sk_if.new_game = 1'b0;
    test_reset();
    test_p1_point();
    test_both_points();
    test_p2_win();
    test_new_game();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish within 500000 time units");
    $fatal(1);
  end

endmodule
